bf16_mul_arbiter: RTL and testbench

Shares the single combinational bf16 multiplier (Mult) between NUM_REQ independent requesters, e.g. the core FPU issue path and a vector/DMA helper. It uses round-robin arbitration with valid/ready handshakes on every request and response port. It registers operands and results, giving a 2-stage pipeline that sustains one multiply per cycle when no response port stalls. Each result returns only on the response port of the requester that issued it.

---
 rtl/fpu_pkg.sv | 8 +
 rtl/bf16_mult.sv | 65 ++++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/bf16_mul_arbiter.sv | 113 +++++++++++
 tb/tb_bf16_mul_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared bf16 type and special-value constants for the multiplier datapath.
package fpu_pkg;
  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_QNAN = 16'h7FC0;
  localparam bf16_t BF16_PINF = 16'h7F80;
  localparam bf16_t BF16_ZERO = 16'h0000;
endpackage

// File: rtl/bf16_mult.sv
// Combinational bf16 multiply, round-to-nearest-even. Subnormal inputs read as zero,
// subnormal results flush to signed zero, every NaN result is the canonical quiet NaN.
module bf16_mult
  import fpu_pkg::*;
(
  input  bf16_t a,
  input  bf16_t b,
  output bf16_t c
);
  logic              sign;
  logic [7:0]        ea, eb;
  logic [6:0]        ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [15:0]       prod;
  logic signed [9:0] exp_raw, exp_n, exp_r;
  logic [6:0]        mant;
  logic              guard, sticky, rnd;
  logic [7:0]        mant_r;

  always_comb begin
    sign   = a[15] ^ b[15];
    ea     = a[14:7];
    eb     = b[14:7];
    ma     = a[6:0];
    mb     = b[6:0];
    a_nan  = (ea == 8'hFF) && (ma != 7'd0);
    b_nan  = (eb == 8'hFF) && (mb != 7'd0);
    a_inf  = (ea == 8'hFF) && (ma == 7'd0);
    b_inf  = (eb == 8'hFF) && (mb == 7'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);

    prod    = {8'b0, 1'b1, ma} * {8'b0, 1'b1, mb};
    exp_raw = signed'({2'b0, ea}) + signed'({2'b0, eb}) - 10'sd127;
    // Product of two [1,2) significands lies in [1,4); normalise the [2,4) case.
    if (prod[15]) begin
      mant   = prod[14:8];
      guard  = prod[7];
      sticky = |prod[6:0];
      exp_n  = exp_raw + 10'sd1;
    end else begin
      mant   = prod[13:7];
      guard  = prod[6];
      sticky = |prod[5:0];
      exp_n  = exp_raw;
    end
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {7'b0, rnd};
    exp_r  = mant_r[7] ? exp_n + 10'sd1 : exp_n;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      c = BF16_QNAN;
    end else if (a_inf || b_inf) begin
      c = {sign, BF16_PINF[14:0]};
    end else if (a_zero || b_zero) begin
      c = {sign, BF16_ZERO[14:0]};
    end else if (exp_r >= 10'sd255) begin
      c = {sign, BF16_PINF[14:0]};
    end else if (exp_r <= 10'sd0) begin
      c = {sign, BF16_ZERO[14:0]};
    end else begin
      c = {sign, exp_r[7:0], mant_r[6:0]};
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr,
// wrapping to the lowest request when nothing at or above ptr is pending.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick;
  logic               found;

  always_comb begin
    req_hi = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_hi[i] = req[i] && (i >= 32'(ptr));
    end
    pick  = (|req_hi) ? req_hi : req;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && pick[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bf16_mul_arbiter.sv
// Shares one bf16 multiplier among NUM_REQ requesters: round-robin grant into an operand
// register, product into a result register, result returned only to its issuer.
module bf16_mul_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*16-1:0] req_a_i,
  input  logic [NUM_REQ*16-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output bf16_t                 rsp_c_o,
  output logic                  busy_o,
  output logic [31:0]           op_cnt_o
);
  logic             v1_q, v2_q;
  logic [ID_W-1:0]  id1_q, id2_q, ptr_q;
  bf16_t            a1_q, b1_q, c2_q;
  logic [31:0]      op_cnt_q;

  logic               drain, adv2, accept, any_grant;
  logic [NUM_REQ-1:0] arb_req, grant;
  logic [ID_W-1:0]    grant_id;
  bf16_t              a_sel, b_sel, mult_c;

  assign drain   = v2_q & rsp_ready_i[id2_q];
  assign adv2    = v1_q & (~v2_q | drain);
  assign accept  = ~v1_q | adv2;
  // Reset masks the grant so no requester sees ready while the pipe is held in reset.
  assign arb_req = accept && !rst_i ? req_valid_i : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_id = '0;
    a_sel    = BF16_ZERO;
    b_sel    = BF16_ZERO;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        a_sel    = req_a_i[16*i +: 16];
        b_sel    = req_b_i[16*i +: 16];
      end
    end
  end

  assign any_grant = |grant;

  bf16_mult u_mult (
    .a (a1_q),
    .b (b1_q),
    .c (mult_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q     <= 1'b0;
      id1_q    <= '0;
      a1_q     <= BF16_ZERO;
      b1_q     <= BF16_ZERO;
      v2_q     <= 1'b0;
      id2_q    <= '0;
      c2_q     <= BF16_ZERO;
      ptr_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      if (any_grant) begin
        v1_q  <= 1'b1;
        id1_q <= grant_id;
        a1_q  <= a_sel;
        b1_q  <= b_sel;
        ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end else if (adv2) begin
        v1_q <= 1'b0;
      end
      // An advance in a drain cycle overwrites stage 2 directly, so no bubble is inserted.
      if (adv2) begin
        v2_q  <= 1'b1;
        id2_q <= id1_q;
        c2_q  <= mult_c;
      end else if (drain) begin
        v2_q <= 1'b0;
      end
      if (drain) begin
        op_cnt_q <= op_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (v2_q) begin
      rsp_valid_o[id2_q] = 1'b1;
    end
  end

  assign req_ready_o = grant;
  assign rsp_c_o     = v2_q ? c2_q : BF16_ZERO;
  assign busy_o      = v1_q | v2_q;
  assign op_cnt_o    = op_cnt_q;
endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Bench for bf16_mul_arbiter: directed vectors and sequences plus randomised traffic, all
// checked every cycle against a queue-based occupancy model with a real-arithmetic multiply.
module tb_bf16_mul_arbiter;
  import fpu_pkg::*;

  localparam int unsigned N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*16-1:0]   req_a, req_b;
  bf16_t             rsp_c;
  logic              busy;
  logic [31:0]       op_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bf16_mul_arbiter #(.NUM_REQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_c_o     (rsp_c),
    .busy_o      (busy),
    .op_cnt_o    (op_cnt)
  );

  always #5 clk = ~clk;

  // Model: in-order queue of accepted ops; each becomes visible at a given cycle.
  typedef struct {int id; bf16_t c; int vis;} ent_t;
  ent_t        q[$];
  int          mptr;
  logic [31:0] mcnt;
  int          cyc = 0;
  logic        m_drain;
  int          m_gnt;

  typedef struct {bf16_t a; bf16_t b; bf16_t c;} vec_t;
  vec_t vt[10];

  function automatic bf16_t ref_mul(input bf16_t a, input bf16_t b);
    logic s;
    int   ea, eb, ma, mb, e2, fl, bexp;
    real  m, fr;
    bit   an, bn, ai, bi, az, bz;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    ma = int'(a[6:0]);  mb = int'(b[6:0]);
    an = (ea == 255) && (ma != 0); bn = (eb == 255) && (mb != 0);
    ai = (ea == 255) && (ma == 0); bi = (eb == 255) && (mb == 0);
    az = (ea == 0);                bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return BF16_QNAN;
    if (ai || bi) return {s, 15'h7F80};
    if (az || bz) return {s, 15'h0000};
    // value = m * 2^e2 exactly; bring m into [128,256) then round the fraction to even.
    m  = real'((128 + ma) * (128 + mb));
    e2 = ea + eb - 268;
    while (m >= 256.0) begin
      m  = m / 2.0;
      e2 = e2 + 1;
    end
    fl = int'($floor(m));
    fr = m - real'(fl);
    if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl = fl + 1;
    if (fl == 256) begin
      fl = 128;
      e2 = e2 + 1;
    end
    bexp = e2 + 7 + 127;
    if (bexp >= 255) return {s, 15'h7F80};
    if (bexp <= 0) return {s, 15'h0000};
    return {s, 8'(bexp), 7'(fl - 128)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mptr    = 0;
    mcnt    = 0;
    m_drain = 1'b0;
    m_gnt   = -1;
  endtask

  // Called at posedge+1 with inputs already applied; predicts and compares all outputs.
  task automatic settle_check();
    logic [N-1:0] e_ready, e_rv;
    bf16_t        e_c;
    logic         e_busy;
    logic [31:0]  e_cnt;
    int           idx;
    #2;
    e_ready = '0; e_rv = '0; e_c = BF16_ZERO; e_busy = 1'b0; e_cnt = '0;
    m_drain = 1'b0;
    m_gnt   = -1;
    if (!rst) begin
      if (q.size() > 0 && cyc >= q[0].vis) begin
        e_rv[q[0].id] = 1'b1;
        e_c           = q[0].c;
        m_drain       = rsp_ready[q[0].id];
      end
      if (q.size() - int'(m_drain) < 2) begin
        for (int i = 0; i < N; i++) begin
          idx = (mptr + i) % N;
          if (m_gnt < 0 && req_valid[idx]) m_gnt = idx;
        end
      end
      if (m_gnt >= 0) e_ready[m_gnt] = 1'b1;
      e_busy = (q.size() > 0);
      e_cnt  = mcnt;
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_c", 32'(rsp_c), 32'(e_c));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("op_cnt", op_cnt, e_cnt);
  endtask

  task automatic tick();
    ent_t h;
    @(posedge clk);
    if (!rst) begin
      if (m_drain) begin
        void'(q.pop_front());
        mcnt = mcnt + 32'd1;
        if (q.size() > 0) begin
          h = q.pop_front();
          if (h.vis < cyc + 1) h.vis = cyc + 1;
          q.push_front(h);
        end
      end
      if (m_gnt >= 0) begin
        h.id  = m_gnt;
        h.c   = ref_mul(req_a[16*m_gnt +: 16], req_b[16*m_gnt +: 16]);
        h.vis = cyc + 2;
        q.push_back(h);
        mptr = (m_gnt + 1) % N;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  task automatic set_op(input int i, input bf16_t a, input bf16_t b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = '1;
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    #1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bf16_t rnd_op();
    bf16_t sp[8];
    sp = '{16'h7FC0, 16'h7F80, 16'hFF80, 16'h0000, 16'h8000, 16'h7F00, 16'h0080, 16'h3F80};
    case ($urandom_range(0, 7))
      0:       return sp[$urandom_range(0, 7)];
      1:       return 16'($urandom);
      default: return {1'($urandom), 8'($urandom_range(100, 154)), 7'($urandom)};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{16'h3FC0, 16'h4000, 16'h4040};
    vt[1] = '{16'h4040, 16'h4000, 16'h40C0};
    vt[2] = '{16'h7FC0, 16'h3F80, BF16_QNAN};
    vt[3] = '{BF16_PINF, BF16_ZERO, BF16_QNAN};
    vt[4] = '{16'hBF80, 16'h4000, 16'hC000};
    vt[5] = '{BF16_ZERO, 16'h4000, BF16_ZERO};
    vt[6] = '{16'h3F81, 16'h3F81, 16'h3F82};
    vt[7] = '{16'h7F00, 16'h4000, BF16_PINF};
    vt[8] = '{16'h0080, 16'h3F00, BF16_ZERO};
    vt[9] = '{16'h3FC0, 16'h3FC0, 16'h4010};

    // Reset state, with requests already asserted.
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    model_reset();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_c", 32'(rsp_c), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_cnt", op_cnt, 32'd0);
    apply_reset();

    // Vector table through requester 0, one op at a time.
    for (int i = 0; i < 10; i++) begin
      req_valid = 4'b0001;
      set_op(0, vt[i].a, vt[i].b);
      cycle();
      req_valid = '0;
      cycle();
      settle_check();
      chk("vec_c", 32'(rsp_c), 32'(vt[i].c));
      chk("vec_valid", 32'(rsp_valid), 32'h1);
      if (i == 0) chk("vec_first_cnt", op_cnt, 32'd0);
      tick();
      if (i == 0) begin
        settle_check();
        chk("single_op_cnt", op_cnt, 32'd1);
        tick();
      end
    end

    // Round-robin with all requesters valid.
    apply_reset();
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < N; r++) set_op(r, rnd_op(), rnd_op());
      settle_check();
      if (i < 8) chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      if (i >= 2) chk("rr_rsp", 32'(rsp_valid), 32'(1 << ((i - 2) % 4)));
      tick();
    end
    req_valid = '0;
    settle_check();
    chk("rr_cnt8", op_cnt, 32'd8);
    tick();
    idle(3);

    // Backpressure on requester 2 with requester 1 queued behind it.
    apply_reset();
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    set_op(2, 16'h4040, 16'h4000);
    cycle();
    req_valid = 4'b0010;
    set_op(1, 16'h3FC0, 16'h4000);
    settle_check();
    chk("bp_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0001;
    set_op(0, 16'h3F80, 16'h3F80);
    for (int i = 0; i < 5; i++) begin
      settle_check();
      chk("bp_hold_valid", 32'(rsp_valid), 32'h4);
      chk("bp_hold_c", 32'(rsp_c), 32'h40C0);
      chk("bp_no_grant", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 4'b1111;
    cycle();
    req_valid = '0;
    settle_check();
    chk("bp_next_valid", 32'(rsp_valid), 32'h2);
    chk("bp_next_c", 32'(rsp_c), 32'h4040);
    tick();
    idle(3);
    settle_check();
    chk("bp_total", op_cnt, 32'd3);
    tick();

    // Sparse requesters around the pointer wrap.
    apply_reset();
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      set_op(0, rnd_op(), rnd_op());
      set_op(3, rnd_op(), rnd_op());
      settle_check();
      chk("wrap_grant", 32'(req_ready), (i == 1) ? 32'h1 : 32'h8);
      tick();
    end
    idle(3);

    // Asynchronous reset with two ops in flight.
    apply_reset();
    req_valid = '1;
    cycle();
    cycle();
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_op_cnt", op_cnt, 32'd0);
    model_reset();
    tick();
    settle_check();
    tick();
    rst = 1'b0;
    settle_check();
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    tick();
    cycle();
    cycle();
    idle(3);

    // Randomised traffic and backpressure.
    for (int i = 0; i < 600; i++) begin
      req_valid = 4'($urandom);
      for (int r = 0; r < N; r++) begin
        set_op(r, rnd_op(), rnd_op());
        rsp_ready[r] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
